// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider returning {remainder, quotient}.
// Optional early-out for |dividend| < |divisor| when DIV_FAST_EN is defined.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  rem_q;
  logic [DATA_W-1:0]  dvd_q;
  logic [DATA_W-1:0]  dsr_q;
  logic               sgn_q;
  logic               sa_q;
  logic               sb_q;
  logic [2*DATA_W-1:0] res_q;

  logic [DATA_W-1:0]  mag_a;
  logic [DATA_W-1:0]  mag_b;
  logic [DATA_W:0]    shifted;
  logic [DATA_W:0]    diff;
  logic               q_bit;
  logic [DATA_W-1:0]  rem_next;
  logic [DATA_W-1:0]  quo_next;
  logic [DATA_W-1:0]  rem_fix;
  logic [DATA_W-1:0]  quo_fix;

  always_comb begin
    mag_a = (signed_div_i && opdata1_i[DATA_W-1]) ? ('0 - opdata1_i) : opdata1_i;
    mag_b = (signed_div_i && opdata2_i[DATA_W-1]) ? ('0 - opdata2_i) : opdata2_i;
    // dvd_q doubles as the quotient shift register: its MSB feeds the
    // remainder while the new quotient bit enters at the LSB.
    shifted  = {rem_q, dvd_q[DATA_W-1]};
    diff     = shifted - {1'b0, dsr_q};
    q_bit    = ~diff[DATA_W];
    rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quo_next = {dvd_q[DATA_W-2:0], q_bit};
    quo_fix  = (sgn_q && (sa_q ^ sb_q)) ? ('0 - quo_next) : quo_next;
    rem_fix  = (sgn_q && sa_q) ? ('0 - rem_next) : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FREE;
      cnt      <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      sgn_q    <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      res_q    <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          result_o <= '0;
          ready_o  <= 1'b0;
          cnt      <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              res_q <= '0;
              state <= BY_ZERO;
            end
`ifdef DIV_FAST_EN
            else if (mag_a < mag_b) begin
              // Shares the BY_ZERO hop so latency matches the zero-divisor case.
              res_q <= {opdata1_i, {DATA_W{1'b0}}};
              state <= BY_ZERO;
            end
`endif
            else begin
              rem_q <= '0;
              dvd_q <= mag_a;
              dsr_q <= mag_b;
              sgn_q <= signed_div_i;
              sa_q  <= opdata1_i[DATA_W-1];
              sb_q  <= opdata2_i[DATA_W-1];
              state <= ON;
            end
          end
        end

        BY_ZERO: begin
          state <= END;
        end

        ON: begin
          if (annul_i || !start_i) begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end else begin
            rem_q <= rem_next;
            dvd_q <= quo_next;
            cnt   <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              res_q <= {rem_fix, quo_fix};
              state <= END;
            end
          end
        end

        END: begin
          if (start_i) begin
            result_o <= res_q;
            ready_o  <= 1'b1;
          end else begin
            state    <= FREE;
            result_o <= '0;
            ready_o  <= 1'b0;
          end
        end

        default: state <= FREE;
      endcase
    end
  end

endmodule
